vga_vsync: RTL
==============

// Module: vga_vsync
// PURPOSE
//   Vertical timing generator, directly downstream of the horizontal timing stage.
//   Consumes the horizontal stage's one-cycle end-of-line pulse (update_vsync) and counts lines
//     through the SYNC, BACK, VISIBLE and FRONT vertical periods.
//   Produces vsync, a vertical-visible qualifier, the visible line index, a frame-start pulse,
//     a frame counter and the combined display-enable.
// PARAMETERS
//   FRONT   1     vertical front porch, in lines (>=1)
//   BACK    38    vertical back porch, in lines (>=1)
//   SYNC    3     vsync pulse width, in lines (>=1)
//   VISIBLE 1024  visible lines per frame (>=1, <=65535)
// PORTS
//   clk           in   1   pixel clock, shared with the horizontal stage
//   reset         in   1   synchronous, active-high reset
//   update_vsync  in   1   one-cycle end-of-line pulse from the horizontal stage
//   hpixel_valid  in   1   horizontal visible qualifier from the horizontal stage
//   vsync         out  1   vertical sync, active low (0 during SYNC)
//   vpixel_valid  out  1   1 while in VISIBLE
//   visible_line  out  16  current visible line index 0..VISIBLE-1; 0 outside VISIBLE
//   frame_start   out  1   one-cycle pulse on entry to VISIBLE
//   frame_count   out  16  completed-frame counter
//   pixel_valid   out  1   hpixel_valid & vpixel_valid (combinational)
// BEHAVIOUR
//   Reset values (sampled on the clk edge with reset=1; reset has priority over update_vsync)
//     - state=SYNC, line_count=0
//     - vsync=0, vpixel_valid=0, visible_line=0, frame_start=0, frame_count=0
//   Register structure
//     - All outputs except pixel_valid are registered.
//     - Next-state logic is combinational; a single clocked register block updates state.
//   Advancement
//     - State and line_count change only on a clk edge where update_vsync=1.
//     - With update_vsync=0, all state holds and frame_start is 0.
//     - Back-to-back update_vsync pulses are each counted as one line.
//   Per-line rule, when update_vsync=1 in state S with period length N:
//     - If line_count==N-1: move to the next state and set line_count to 0.
//     - Otherwise: line_count+1.
//   Transitions; outputs change on the same edge as the transition (1 cycle after the pulse is sampled)
//     - SYNC->BACK: vsync<=1
//     - BACK->VISIBLE: vpixel_valid<=1, frame_start<=1 for exactly one cycle, visible_line<=0
//     - VISIBLE->FRONT: vpixel_valid<=0, visible_line<=0
//     - FRONT->SYNC: vsync<=0, frame_count<=frame_count+1 (wraps 0xFFFF->0)
//   visible_line
//     - Equals line_count while in VISIBLE.
//     - Updates on the same edge as line_count.
//   Counters
//     - line_count is 16 bits; only compared for equality against parameter-1.
//   Frame and reset timing
//     - Frame length is SYNC+BACK+VISIBLE+FRONT lines.
//     - After reset, the first update_vsync pulse counts as line 0 of SYNC completing.
//     - The horizontal stage also resets into its own SYNC state, so both stages align.
//     - A reset mid-frame returns the block to its reset values on the next edge, with no partial outputs.
//   Illegal states (encodings outside the four states)
//     - Go to SYNC with line_count=0 on the next edge.
// TESTING  (SYNC=2, BACK=3, VISIBLE=4, FRONT=1 unless noted)
//   1. Reset, then 2 update_vsync pulses -> vsync 0->1 one cycle after 2nd pulse; vpixel_valid stays 0
//   2. 3 further pulses (5 total) -> vpixel_valid=1 and frame_start=1 one cycle after 5th pulse,
//      frame_start=0 on the following cycle, visible_line=0
//   3. Pulses 6..9 -> visible_line 1,2,3 then vpixel_valid=0 and visible_line=0 after 9th
//   4. 10th pulse -> vsync=0, frame_count 0->1; run 3 full frames -> frame_count=3, period 10 lines each
//   5. Assert reset while visible_line=2 -> next cycle: vsync=0, vpixel_valid=0, frame_count=0,
//      visible_line=0; the sequence then restarts as in test 1
//   6. Default params, pulses every cycle, plus hpixel_valid toggling -> vsync high after 3 lines,
//      first frame_start after 41 lines; pixel_valid=1 only when both qualifiers are 1;
//      no pulses for 100 cycles -> all outputs hold

Source files
------------

// File: rtl/vga_vsync.sv
// Vertical timing generator for a VGA-style raster.
// Counts end-of-line pulses from the horizontal stage through the
// SYNC, BACK, VISIBLE and FRONT periods of each frame. All outputs are
// registered except pixel_valid, which gates the horizontal qualifier with
// the registered vertical qualifier.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ST_SYNC    | vsync asserted (low), counting SYNC lines
//   ST_BACK    | back porch, vsync high, counting BACK lines
//   ST_VISIBLE | visible lines, vpixel_valid high, line index out
//   ST_FRONT   | front porch, frame counter bumps on exit
module vga_vsync #(
  parameter int FRONT   = 1,
  parameter int BACK    = 38,
  parameter int SYNC    = 3,
  parameter int VISIBLE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        update_vsync,
  input  logic        hpixel_valid,
  output logic        vsync,
  output logic        vpixel_valid,
  output logic [15:0] visible_line,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        pixel_valid
);

  // Last line index of each period; line_count is only ever compared for
  // equality against these, so no magnitude compare is needed.
  localparam logic [15:0] L_SYNC_LAST    = 16'(SYNC - 1);
  localparam logic [15:0] L_BACK_LAST    = 16'(BACK - 1);
  localparam logic [15:0] L_VISIBLE_LAST = 16'(VISIBLE - 1);
  localparam logic [15:0] L_FRONT_LAST   = 16'(FRONT - 1);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_BACK    = 2'd1,
    ST_VISIBLE = 2'd2,
    ST_FRONT   = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_line_count;
  logic        r_vsync;
  logic        r_vpixel_valid;
  logic [15:0] r_visible_line;
  logic        r_frame_start;
  logic [15:0] r_frame_count;

  state_t      w_state_nxt;
  logic [15:0] w_line_count_nxt;
  logic [15:0] w_line_count_inc;
  logic        w_vsync_nxt;
  logic        w_vpixel_valid_nxt;
  logic [15:0] w_visible_line_nxt;
  logic        w_frame_start_nxt;
  logic [15:0] w_frame_count_nxt;

  assign w_line_count_inc = r_line_count + 16'd1;

  // Single register block for state, line counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_SYNC;
      r_line_count   <= 16'd0;
      r_vsync        <= 1'b0;
      r_vpixel_valid <= 1'b0;
      r_visible_line <= 16'd0;
      r_frame_start  <= 1'b0;
      r_frame_count  <= 16'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_line_count   <= w_line_count_nxt;
      r_vsync        <= w_vsync_nxt;
      r_vpixel_valid <= w_vpixel_valid_nxt;
      r_visible_line <= w_visible_line_nxt;
      r_frame_start  <= w_frame_start_nxt;
      r_frame_count  <= w_frame_count_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a line ends.
  always_comb begin
    w_state_nxt        = r_state;
    w_line_count_nxt   = r_line_count;
    w_vsync_nxt        = r_vsync;
    w_vpixel_valid_nxt = r_vpixel_valid;
    w_visible_line_nxt = r_visible_line;
    w_frame_start_nxt  = 1'b0;
    w_frame_count_nxt  = r_frame_count;

    case (r_state)
      ST_SYNC: begin
        if (update_vsync) begin
          if (r_line_count == L_SYNC_LAST) begin
            w_state_nxt      = ST_BACK;
            w_line_count_nxt = 16'd0;
            w_vsync_nxt      = 1'b1;
          end else begin
            w_line_count_nxt = w_line_count_inc;
          end
        end
      end

      ST_BACK: begin
        if (update_vsync) begin
          if (r_line_count == L_BACK_LAST) begin
            w_state_nxt        = ST_VISIBLE;
            w_line_count_nxt   = 16'd0;
            w_vpixel_valid_nxt = 1'b1;
            w_frame_start_nxt  = 1'b1;
            w_visible_line_nxt = 16'd0;
          end else begin
            w_line_count_nxt = w_line_count_inc;
          end
        end
      end

      ST_VISIBLE: begin
        if (update_vsync) begin
          if (r_line_count == L_VISIBLE_LAST) begin
            w_state_nxt        = ST_FRONT;
            w_line_count_nxt   = 16'd0;
            w_vpixel_valid_nxt = 1'b0;
            w_visible_line_nxt = 16'd0;
          end else begin
            // visible_line tracks line_count on the same edge
            w_line_count_nxt   = w_line_count_inc;
            w_visible_line_nxt = w_line_count_inc;
          end
        end
      end

      ST_FRONT: begin
        if (update_vsync) begin
          if (r_line_count == L_FRONT_LAST) begin
            w_state_nxt       = ST_SYNC;
            w_line_count_nxt  = 16'd0;
            w_vsync_nxt       = 1'b0;
            w_frame_count_nxt = r_frame_count + 16'd1;
          end else begin
            w_line_count_nxt = w_line_count_inc;
          end
        end
      end

      default: begin
        // Corrupted state register: recover to the start of a frame
        // immediately, without waiting for a line pulse.
        w_state_nxt        = ST_SYNC;
        w_line_count_nxt   = 16'd0;
        w_vsync_nxt        = 1'b0;
        w_vpixel_valid_nxt = 1'b0;
        w_visible_line_nxt = 16'd0;
      end
    endcase
  end

  assign vsync        = r_vsync;
  assign vpixel_valid = r_vpixel_valid;
  assign visible_line = r_visible_line;
  assign frame_start  = r_frame_start;
  assign frame_count  = r_frame_count;
  assign pixel_valid  = hpixel_valid & r_vpixel_valid;

endmodule
